// File: rtl/axi4_mem_slave.sv
// axi4_mem_slave: AXI4 responder backed by a DEPTH x 32-bit word array mapped at BASE_ADDR.
// Independent write (AW/W/B) and read (AR/R) state machines; every output is a register.
// Optional define AXI4_SLV_BP_EN: backpressure test mode (wready low every other data
// cycle, one idle cycle with rvalid=0 after each read beat).
module axi4_mem_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int          DEPTH     = 64,
    parameter int          ID_W      = 2
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [ID_W-1:0] awid,
    input  logic [31:0]     awaddr,
    input  logic [7:0]      awlen,
    input  logic [1:0]      awburst,
    input  logic            awvalid,
    output logic            awready,
    input  logic [31:0]     wdata,
    input  logic [3:0]      wstrb,
    input  logic            wlast,
    input  logic            wvalid,
    output logic            wready,
    output logic [ID_W-1:0] bid,
    output logic [1:0]      bresp,
    output logic            bvalid,
    input  logic            bready,
    input  logic [ID_W-1:0] arid,
    input  logic [31:0]     araddr,
    input  logic [7:0]      arlen,
    input  logic [1:0]      arburst,
    input  logic            arvalid,
    output logic            arready,
    output logic [ID_W-1:0] rid,
    output logic [31:0]     rdata,
    output logic [1:0]      rresp,
    output logic            rlast,
    output logic            rvalid,
    input  logic            rready
);
    localparam int          IDX_W       = $clog2(DEPTH);
    localparam logic [31:0] SPAN        = 32'(4 * DEPTH);
    localparam logic [1:0]  BURST_FIXED = 2'd0;
    localparam logic [1:0]  BURST_INCR  = 2'd1;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

`ifdef AXI4_SLV_BP_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    logic [31:0] mem [DEPTH];

    w_state_e        w_state_q, w_state_d;
    logic            awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [ID_W-1:0] bid_q, bid_d;
    logic [1:0]      bresp_q, bresp_d, w_burst_q, w_burst_d;
    logic [31:0]     w_addr_q, w_addr_d;
    logic [7:0]      w_len_q, w_len_d, w_beat_q, w_beat_d;
    logic            w_err_q, w_err_d;

    r_state_e        r_state_q, r_state_d;
    logic            arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [ID_W-1:0] rid_q, rid_d;
    logic [31:0]     rdata_q, rdata_d, r_addr_q, r_addr_d;
    logic [1:0]      rresp_q, rresp_d, r_burst_q, r_burst_d;
    logic [7:0]      r_len_q, r_len_d, r_beat_q, r_beat_d;

    // Write beat decode: offset into the window, burst legality, wlast agreement.
    logic [31:0]      w_off;
    logic [IDX_W-1:0] mem_idx;
    logic             w_in_range, w_burst_ok, w_is_last, w_beat_err, mem_we;
    assign w_off      = w_addr_q - BASE_ADDR;
    assign mem_idx    = w_off[IDX_W+1:2];
    assign w_in_range = (w_off < SPAN);
    assign w_burst_ok = (w_burst_q == BURST_FIXED) || (w_burst_q == BURST_INCR);
    assign w_is_last  = (w_beat_q == w_len_q);
    assign w_beat_err = !w_burst_ok || !w_in_range || (wlast != w_is_last);

    // Read beat decode: address of the beat being loaded into the R output register.
    logic [31:0] r_next_addr, rd_addr, rd_off, rd_word;
    logic [1:0]  rd_burst, rd_resp;
    logic        rd_ok;
    assign r_next_addr = (r_burst_q == BURST_INCR) ? r_addr_q + 32'd4 : r_addr_q;
    assign rd_off      = rd_addr - BASE_ADDR;
    assign rd_ok       = ((rd_burst == BURST_FIXED) || (rd_burst == BURST_INCR)) && (rd_off < SPAN);
    assign rd_word     = rd_ok ? mem[rd_off[IDX_W+1:2]] : 32'd0;
    assign rd_resp     = rd_ok ? RESP_OKAY : RESP_SLVERR;

    // Pick the read address: the AR request when idle, else the next or current beat.
    always_comb begin
        rd_addr  = r_addr_q;
        rd_burst = r_burst_q;
        if (r_state_q == R_IDLE) begin
            rd_addr  = araddr;
            rd_burst = arburst;
        end else if (rvalid_q) begin
            rd_addr = r_next_addr;
        end
    end

    // Write FSM next-state: AW capture, beat acceptance with error accumulation, B response.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_burst_d = w_burst_q;
        w_beat_d  = w_beat_q;
        w_err_d   = w_err_q;
        mem_we    = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                awready_d = 1'b1;
                if (awvalid && awready_q) begin
                    bid_d     = awid;
                    w_addr_d  = awaddr;
                    w_len_d   = awlen;
                    w_burst_d = awburst;
                    w_beat_d  = 8'd0;
                    w_err_d   = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (BP_EN) wready_d = !wready_q;
                if (wvalid && wready_q) begin
                    mem_we  = w_burst_ok && w_in_range;
                    w_err_d = w_err_q || w_beat_err;
                    // The burst ends on the beat count; wlast only affects the response.
                    if (w_is_last) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        bresp_d   = (w_err_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                        w_state_d = W_RESP;
                    end else begin
                        w_beat_d = w_beat_q + 8'd1;
                        w_addr_d = (w_burst_q == BURST_INCR) ? w_addr_q + 32'd4 : w_addr_q;
                    end
                end
            end
            W_RESP: begin
                if (bready && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read FSM next-state: AR capture, beat load, hold while stalled, optional idle gap.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rid_d     = rid_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_burst_d = r_burst_q;
        r_beat_d  = r_beat_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (arvalid && arready_q) begin
                    rid_d     = arid;
                    r_addr_d  = araddr;
                    r_len_d   = arlen;
                    r_burst_d = arburst;
                    r_beat_d  = 8'd0;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_word;
                    rresp_d   = rd_resp;
                    rlast_d   = (arlen == 8'd0);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (!rvalid_q) begin
                    rvalid_d = 1'b1;
                    rdata_d  = rd_word;
                    rresp_d  = rd_resp;
                    rlast_d  = (r_beat_q == r_len_q);
                end else if (rready) begin
                    if (r_beat_q == r_len_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        r_addr_d = r_next_addr;
                        r_beat_d = r_beat_q + 8'd1;
                        if (BP_EN) begin
                            rvalid_d = 1'b0;
                            rlast_d  = 1'b0;
                        end else begin
                            rvalid_d = 1'b1;
                            rdata_d  = rd_word;
                            rresp_d  = rd_resp;
                            rlast_d  = ((r_beat_q + 8'd1) == r_len_q);
                        end
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // State and output registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= 2'b00;
            w_addr_q  <= 32'd0;
            w_len_q   <= 8'd0;
            w_burst_q <= 2'd0;
            w_beat_q  <= 8'd0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'b00;
            rid_q     <= '0;
            r_addr_q  <= 32'd0;
            r_len_q   <= 8'd0;
            r_burst_q <= 2'd0;
            r_beat_q  <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_burst_q <= w_burst_d;
            w_beat_q  <= w_beat_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rid_q     <= rid_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_burst_q <= r_burst_d;
            r_beat_q  <= r_beat_d;
        end
    end

    // Byte-masked array write; a same-edge read sees the old word.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; contents are undefined until written, and a reset would force it into flops.
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[mem_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rlast   = rlast_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rid     = rid_q;

endmodule

// File: tb/tb_axi4_mem_slave.sv
// Bench for axi4_mem_slave: randomized AXI4 master tasks, a word-array reference model,
// and a monitor that pops expected B/R responses from queues at each handshake.
`timescale 1ns/1ps
module tb_axi4_mem_slave;
    localparam logic [31:0] BASE_ADDR = 32'h8000_0000;
    localparam int          DEPTH     = 64;
    localparam int          ID_W      = 2;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic [ID_W-1:0] awid = '0, arid = '0, bid, rid;
    logic [31:0]     awaddr = '0, araddr = '0, wdata = '0, rdata;
    logic [7:0]      awlen = '0, arlen = '0;
    logic [1:0]      awburst = '0, arburst = '0, bresp, rresp;
    logic [3:0]      wstrb = '0;
    logic            awvalid = 1'b0, wvalid = 1'b0, wlast = 1'b0, arvalid = 1'b0;
    logic            bready = 1'b0, rready = 1'b0;
    logic            awready, wready, bvalid, arready, rvalid, rlast;

    always #5 clk = ~clk;

    axi4_mem_slave #(.BASE_ADDR(BASE_ADDR), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk(clk), .rstn(rstn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    typedef struct { logic [ID_W-1:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct { logic [ID_W-1:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;

    b_exp_t      exp_b[$];
    r_exp_t      exp_r[$];
    logic [31:0] model [DEPTH];
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          rmode   = 0;   // 0 always ready, 1 toggle, 2 random, 3 never
    int          bmode   = 0;   // 0 always ready, 1 random
    bit          wgaps   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int n, input logic [1:0] burst);
        return (burst == 2'd1) ? start + 32'(4 * n) : start;
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        return (a >= BASE_ADDR) && (a < BASE_ADDR + 32'(4 * DEPTH));
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a - BASE_ADDR) >> 2);
    endfunction

    // Ready-side drivers, updated just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        case (rmode)
            0:       rready = 1'b1;
            1:       rready = !rready;
            2:       rready = ($urandom_range(0, 3) != 0);
            default: rready = 1'b0;
        endcase
        bready = (bmode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
    end

    // Monitor: compare each B/R handshake against the scoreboard; check R hold under stall.
    b_exp_t      mon_b;
    r_exp_t      mon_r;
    logic        stall_q = 1'b0;
    logic [31:0] held_data;
    logic        held_last;
    always @(negedge clk) begin
        if (!rstn) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("r_hold_valid", rvalid, 1);
                check("r_hold_data", rdata, held_data);
                check("r_hold_last", rlast, held_last);
            end
            if (bvalid && bready) begin
                if (exp_b.size() == 0) check("b_unexpected", bvalid, 0);
                else begin
                    mon_b = exp_b.pop_front();
                    check("bid", bid, mon_b.id);
                    check("bresp", bresp, mon_b.resp);
                end
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) check("r_unexpected", rvalid, 0);
                else begin
                    mon_r = exp_r.pop_front();
                    check("rid", rid, mon_r.id);
                    check("rdata", rdata, mon_r.data);
                    check("rresp", rresp, mon_r.resp);
                    check("rlast", rlast, mon_r.last);
                end
            end
            stall_q   = rvalid && !rready;
            held_data = rdata;
            held_last = rlast;
        end
    end

    // which: 0 awready, 1 wready, 2 arready, 3 rvalid. Returns at a falling edge with it seen high.
    task automatic wait_ready(input int which, input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            case (which)
                0:       ok = awready;
                1:       ok = wready;
                2:       ok = arready;
                default: ok = rvalid;
            endcase
            if (ok) break;
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: handshake not seen within 500 cycles", name);
        end
    endtask

    // Write burst from wd/ws; bad_last >= 0 flips wlast on that beat.
    task automatic do_write(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input int bad_last);
        bit          err;
        bit          ok;
        logic [31:0] a;
        b_exp_t      e;
        err = (burst > 2'd1) || (bad_last >= 0);
        for (int n = 0; n <= len; n++) begin
            a = beat_addr(addr, n, burst);
            if (!in_range(a)) err = 1'b1;
            else if (burst <= 2'd1) begin
                for (int b = 0; b < 4; b++)
                    if (ws[n][b]) model[word_of(a)][8*b +: 8] = wd[n][8*b +: 8];
            end
        end
        e.id   = id;
        e.resp = err ? 2'b10 : 2'b00;
        exp_b.push_back(e);
        awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
        wait_ready(0, "aw_handshake", ok);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        if (!ok) return;
        for (int n = 0; n <= len; n++) begin
            if (wgaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            wdata = wd[n]; wstrb = ws[n]; wlast = ((n == len) != (n == bad_last)); wvalid = 1'b1;
            wait_ready(1, "w_handshake", ok);
            @(posedge clk);
            #1;
            wvalid = 1'b0;
            wlast  = 1'b0;
            if (!ok) return;
        end
    endtask

    task automatic do_read(input logic [ID_W-1:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst);
        bit          ok;
        logic [31:0] a;
        r_exp_t      e;
        for (int n = 0; n <= len; n++) begin
            a      = beat_addr(addr, n, burst);
            e.id   = id;
            e.last = (n == len);
            if (burst <= 2'd1 && in_range(a)) begin
                e.data = model[word_of(a)];
                e.resp = 2'b00;
            end else begin
                e.data = 32'd0;
                e.resp = 2'b10;
            end
            exp_r.push_back(e);
        end
        arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arvalid = 1'b1;
        wait_ready(2, "ar_handshake", ok);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 3000 && (exp_b.size() != 0 || exp_r.size() != 0); i++) @(negedge clk);
        check({name, "_drained"}, 32'(exp_b.size() + exp_r.size()), 32'd0);
        exp_b.delete();
        exp_r.delete();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ok;
        logic [31:0] a0;
        int          len, sel, bad;
        logic [1:0]  bt;

        for (int i = 0; i < DEPTH; i++) model[i] = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awready", awready, 0);
        check("rst_arready", arready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_rdata", rdata, 0);
        check("rst_resp", {bresp, rresp, bid, rid}, 0);
        rstn = 1'b1;
        #1;
        check("rel_awready_before_clk", awready, 0);
        @(negedge clk);
        check("rel_awready", awready, 1);
        check("rel_arready", arready, 1);
        @(posedge clk);
        #1;

        // Preload every word with known random data.
        for (int k = 0; k < DEPTH / 16; k++) begin
            for (int n = 0; n < 16; n++) begin wd[n] = $urandom; ws[n] = 4'hF; end
            do_write(2'(k), BASE_ADDR + 32'(64 * k), 15, 2'd1, -1);
            wait_drain("preload");
        end

        // 16-beat INCR write of address-as-data, then read back.
        for (int n = 0; n < 16; n++) begin wd[n] = BASE_ADDR + 32'(4 * n); ws[n] = 4'hF; end
        do_write(2'd1, BASE_ADDR, 15, 2'd1, -1);
        wait_drain("incr16_write");
        do_read(2'd2, BASE_ADDR, 15, 2'd1);
        wait_drain("incr16_read");

        // Partial strobe merge.
        wd[0] = 32'h1122_3344; ws[0] = 4'hF;
        do_write(2'd0, BASE_ADDR + 32'h10, 0, 2'd1, -1);
        wait_drain("strobe_full");
        wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0011;
        do_write(2'd3, BASE_ADDR + 32'h10, 0, 2'd1, -1);
        wait_drain("strobe_part");
        do_read(2'd3, BASE_ADDR + 32'h10, 0, 2'd1);
        wait_drain("strobe_read");

        // Out-of-range read, unsupported bursts.
        do_read(2'd3, BASE_ADDR + 32'h100, 0, 2'd1);
        wait_drain("oor_read");
        for (int n = 0; n < 4; n++) begin wd[n] = $urandom; ws[n] = 4'hF; end
        do_write(2'd2, BASE_ADDR, 3, 2'd2, -1);
        wait_drain("burst2_write");
        do_read(2'd1, BASE_ADDR, 3, 2'd1);
        wait_drain("burst2_unchanged");
        do_read(2'd0, BASE_ADDR, 2, 2'd3);
        wait_drain("burst3_read");

        // FIXED bursts: all beats hit one word.
        for (int n = 0; n < 4; n++) begin wd[n] = $urandom; ws[n] = (n == 0) ? 4'hF : 4'($urandom); end
        do_write(2'd1, BASE_ADDR + 32'h20, 3, 2'd0, -1);
        wait_drain("fixed_write");
        do_read(2'd2, BASE_ADDR + 32'h20, 3, 2'd0);
        wait_drain("fixed_read");

        // wlast early and late: SLVERR, data still written.
        for (int n = 0; n < 4; n++) begin wd[n] = $urandom; ws[n] = 4'hF; end
        do_write(2'd0, BASE_ADDR + 32'h40, 3, 2'd1, 1);
        wait_drain("wlast_early");
        for (int n = 0; n < 4; n++) begin wd[n] = $urandom; ws[n] = 4'hF; end
        do_write(2'd1, BASE_ADDR + 32'h50, 3, 2'd1, 3);
        wait_drain("wlast_late");
        do_read(2'd1, BASE_ADDR + 32'h40, 7, 2'd1);
        wait_drain("wlast_read");

        // Bursts running off the end of the window and wrapping the 32-bit space.
        for (int n = 0; n < 4; n++) begin wd[n] = $urandom; ws[n] = 4'hF; end
        do_write(2'd1, BASE_ADDR + 32'(4 * (DEPTH - 2)), 3, 2'd1, -1);
        wait_drain("edge_write");
        do_read(2'd2, BASE_ADDR + 32'(4 * (DEPTH - 2)), 3, 2'd1);
        wait_drain("edge_read");
        do_read(2'd3, 32'hFFFF_FFF8, 3, 2'd1);
        wait_drain("wrap_read");

        // Concurrent write and read on disjoint words, rready toggling.
        rmode = 1;
        for (int n = 0; n < 16; n++) begin wd[n] = $urandom; ws[n] = 4'($urandom); end
        fork
            do_write(2'd1, BASE_ADDR, 15, 2'd1, -1);
            do_read(2'd2, BASE_ADDR + 32'h80, 15, 2'd1);
        join
        wait_drain("concurrent");
        rmode = 0;
        do_read(2'd0, BASE_ADDR, 15, 2'd1);
        wait_drain("concurrent_check");

        // Randomized traffic with random ready and wvalid gaps.
        rmode = 2; bmode = 1; wgaps = 1'b1;
        for (int it = 0; it < 40; it++) begin
            len = $urandom_range(0, 15);
            sel = $urandom_range(0, 9);
            bt  = (sel < 6) ? 2'd1 : (sel < 9) ? 2'd0 : 2'($urandom_range(2, 3));
            if ($urandom_range(0, 7) == 0) a0 = BASE_ADDR + 32'(4 * $urandom_range(DEPTH - 4, DEPTH + 4));
            else                           a0 = BASE_ADDR + 32'(4 * $urandom_range(0, DEPTH - 1));
            if ($urandom_range(0, 1) == 1) begin
                for (int n = 0; n <= len; n++) begin wd[n] = $urandom; ws[n] = 4'($urandom); end
                bad = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len)) : -1;
                do_write(2'($urandom), a0, len, bt, bad);
            end else begin
                do_read(2'($urandom), a0, len, bt);
            end
            wait_drain("rand");
        end
        rmode = 0; bmode = 0; wgaps = 1'b0;

        // Reset pulsed during a stalled read burst.
        rmode = 3;
        repeat (2) @(posedge clk);
        #1;
        araddr = BASE_ADDR; arlen = 8'd7; arburst = 2'd1; arid = 2'd1; arvalid = 1'b1;
        wait_ready(2, "rst_ar", ok);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        wait_ready(3, "rst_rvalid", ok);
        check("rst_mid_rvalid", rvalid, 1);
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_rvalid_cleared", rvalid, 0);
        check("rst_mid_arready_cleared", arready, 0);
        check("rst_mid_rdata_cleared", rdata, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        check("rst_arready_before_clk", arready, 0);
        @(negedge clk);
        check("rst_arready_after", arready, 1);
        check("rst_awready_after", awready, 1);
        check("rst_rvalid_after", rvalid, 0);
        rmode = 0;
        @(posedge clk);
        #1;
        do_read(2'd0, BASE_ADDR, 7, 2'd1);
        wait_drain("post_reset_read");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
